fifo_serializer: RTL and testbench

FIFO_SERIALIZER -- requirements
Module: fifo_serializer

---
 rtl/fifo_serializer.sv | 121 ++++++++++++
 tb/tb_fifo_serializer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_serializer.sv
// Splits each IN_WIDTH FIFO word into RATIO beats (LSB first). The first beat appears 1 cycle after the pop.
// Downstream stalls (ready_i=0) hold the current beat, and the next word is popped on the final beat's handshake.
module fifo_serializer #(
  parameter int IN_WIDTH = 32,
  parameter int RATIO    = 4,
  localparam int OUT_WIDTH = IN_WIDTH / ((RATIO > 0) ? RATIO : 1),
  localparam int CNT_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic [IN_WIDTH-1:0]  fifo_data_i,
  input  logic                 fifo_empty_i,
  output logic                 fifo_pop_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [OUT_WIDTH-1:0] data_o,
  output logic                 last_o,
  output logic                 busy_o
);

  generate
    if (RATIO < 1) begin : g_bad_ratio
      $error("fifo_serializer: RATIO must be at least 1");
    end else if (IN_WIDTH % RATIO != 0) begin : g_bad_width
      $error("fifo_serializer: IN_WIDTH must be a multiple of RATIO");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    SER  = 1'b1
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(RATIO - 1);

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [IN_WIDTH-1:0]   word_q, word_d;
  logic                  pop;
  logic                  hs;
  logic                  at_last;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

  assign valid_o = (state_q == SER);
  assign busy_o  = (state_q == SER);
  assign at_last = (cnt_q == CNT_LAST);
  assign last_o  = valid_o & at_last;
  assign hs      = valid_o & ready_i;

  // Reset must block the pop even though the FSM itself only sees reset at the edge.
  assign fifo_pop_o = pop & rst_ni;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    pop     = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty_i) begin
            pop     = 1'b1;
            word_d  = fifo_data_i;
            cnt_d   = '0;
            state_d = SER;
          end
        end
        SER: begin
          if (hs) begin
            if (!at_last) begin
              cnt_d = cnt_q + CNT_WIDTH'(1);
            end else if (!fifo_empty_i) begin
              pop    = 1'b1;
              word_d = fifo_data_i;
              cnt_d  = '0;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    data_o = word_q[OUT_WIDTH-1:0];
    for (int b = 1; b < RATIO; b++) begin
      if (cnt_q == CNT_WIDTH'(b)) data_o = word_q[b*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  a_no_pop_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(fifo_pop_o && fifo_empty_i));

  a_valid_holds: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_o && !ready_i && !flush_i) |=> valid_o);

  a_beat_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_o && !ready_i && !flush_i) |=> ($stable(data_o) && $stable(last_o)));

endmodule

// File: tb/tb_fifo_serializer.sv
// Bench for fifo_serializer: directed scenarios on a 32/4 and an 8/1 instance plus a
// randomized run against a word-level reference model of the beat stream.
module tb_fifo_serializer;

  logic        clk = 1'b0;
  logic        rst_n, flush, ready;
  logic [31:0] a_data;
  logic        a_empty, a_pop, a_vld, a_last, a_busy;
  logic [7:0]  a_dat;
  logic [7:0]  b_data;
  logic        b_empty, b_pop, b_vld, b_last, b_busy;
  logic [7:0]  b_dat;

  logic        sa_pop, sa_vld, sa_last, sa_busy;
  logic [7:0]  sa_dat;
  logic        sb_pop, sb_vld, sb_last, sb_busy;
  logic [7:0]  sb_dat;

  logic [31:0] fqa[$];
  logic [7:0]  fqb[$];

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fifo_serializer #(.IN_WIDTH(32), .RATIO(4)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .fifo_data_i(a_data), .fifo_empty_i(a_empty), .fifo_pop_o(a_pop),
    .valid_o(a_vld), .ready_i(ready), .data_o(a_dat), .last_o(a_last), .busy_o(a_busy)
  );

  fifo_serializer #(.IN_WIDTH(8), .RATIO(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .fifo_data_i(b_data), .fifo_empty_i(b_empty), .fifo_pop_o(b_pop),
    .valid_o(b_vld), .ready_i(ready), .data_o(b_dat), .last_o(b_last), .busy_o(b_busy)
  );

  task automatic upd();
    a_empty = (fqa.size() == 0);
    a_data  = (fqa.size() != 0) ? fqa[0] : 32'h0;
    b_empty = (fqb.size() == 0);
    b_data  = (fqb.size() != 0) ? fqb[0] : 8'h0;
  endtask

  // Sample both DUTs mid-cycle, then let the edge happen and apply pops to the bench FIFOs.
  task automatic cycle();
    logic [31:0] ta;
    logic [7:0]  tb;
    @(negedge clk);
    sa_pop = a_pop; sa_vld = a_vld; sa_dat = a_dat; sa_last = a_last; sa_busy = a_busy;
    sb_pop = b_pop; sb_vld = b_vld; sb_dat = b_dat; sb_last = b_last; sb_busy = b_busy;
    @(posedge clk); #1;
    if (sa_pop && fqa.size() != 0) ta = fqa.pop_front();
    if (sb_pop && fqb.size() != 0) tb = fqb.pop_front();
    upd();
  endtask

  function automatic logic [7:0] beat_of(logic [31:0] w, int k);
    return 8'((w >> (8 * k)) & 32'hFF);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; ready = 1'b1;
    fqa.push_back(32'h12345678); fqb.push_back(8'h99); upd();
    cycle();
    cycle();
    tests_run++;
    if ({sa_pop, sa_vld, sa_last, sa_busy, sa_dat} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_a: got pop/vld/last/busy/dat=%h want 000", {sa_pop, sa_vld, sa_last, sa_busy, sa_dat});
    end
    tests_run++;
    if ({sb_pop, sb_vld, sb_last, sb_busy, sb_dat} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_b: got pop/vld/last/busy/dat=%h want 000", {sb_pop, sb_vld, sb_last, sb_busy, sb_dat});
    end
    fqa.delete(); fqb.delete(); upd();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_single();
    logic [31:0] w = 32'hDDCCBBAA;
    ready = 1'b1;
    fqa.push_back(w); upd();
    cycle();
    tests_run++;
    if ({sa_pop, sa_vld} !== 2'b10) begin
      tests_failed++;
      $display("FAIL single_pop: got pop,vld=%b want 10", {sa_pop, sa_vld});
    end
    for (int k = 0; k < 4; k++) begin
      cycle();
      tests_run++;
      if ({sa_vld, sa_last, sa_pop, sa_dat} !== {1'b1, (k == 3), 1'b0, beat_of(w, k)}) begin
        tests_failed++;
        $display("FAIL single_beat%0d: got vld,last,pop,dat=%b%b%b %h want 1%b0 %h",
                 k, sa_vld, sa_last, sa_pop, sa_dat, (k == 3), beat_of(w, k));
      end
    end
    cycle();
    tests_run++;
    if ({sa_vld, sa_busy, sa_last} !== 3'b000) begin
      tests_failed++;
      $display("FAIL single_idle: got vld,busy,last=%b want 000", {sa_vld, sa_busy, sa_last});
    end
  endtask

  task automatic test_back_to_back();
    ready = 1'b1;
    fqa.push_back(32'h03020100); fqa.push_back(32'h07060504); upd();
    cycle();
    tests_run++;
    if (sa_pop !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_first_pop: got %b want 1", sa_pop);
    end
    for (int k = 0; k < 8; k++) begin
      cycle();
      tests_run++;
      if ({sa_vld, sa_last, sa_pop, sa_dat} !== {1'b1, (k % 4 == 3), (k == 3), 8'(k)}) begin
        tests_failed++;
        $display("FAIL b2b_beat%0d: got vld,last,pop=%b%b%b dat=%h want 1%b%b dat=%h",
                 k, sa_vld, sa_last, sa_pop, sa_dat, (k % 4 == 3), (k == 3), 8'(k));
      end
    end
    cycle();
    tests_run++;
    if (sa_vld !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_idle: got vld=%b want 0", sa_vld);
    end
  endtask

  task automatic test_stall();
    logic [31:0] w = 32'hDDCCBBAA;
    ready = 1'b1;
    fqa.push_back(w); upd();
    cycle();
    cycle();
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      tests_run++;
      if ({sa_vld, sa_last, sa_pop, sa_dat} !== {3'b100, 8'hBB}) begin
        tests_failed++;
        $display("FAIL stall_cyc%0d: got vld,last,pop=%b%b%b dat=%h want 100 dat=bb",
                 k, sa_vld, sa_last, sa_pop, sa_dat);
      end
    end
    ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      cycle();
      tests_run++;
      if ({sa_vld, sa_last, sa_dat} !== {1'b1, (k == 3), beat_of(w, k)}) begin
        tests_failed++;
        $display("FAIL stall_resume%0d: got vld,last=%b%b dat=%h want 1%b dat=%h",
                 k, sa_vld, sa_last, sa_dat, (k == 3), beat_of(w, k));
      end
    end
    cycle();
  endtask

  task automatic test_flush();
    logic [31:0] w2 = 32'h44332211;
    ready = 1'b1;
    fqa.push_back(32'hDDCCBBAA); upd();
    cycle();
    cycle();
    cycle();
    fqa.push_back(w2); upd();
    flush = 1'b1;
    cycle();
    tests_run++;
    if ({sa_vld, sa_pop, sa_dat} !== {2'b10, 8'hCC}) begin
      tests_failed++;
      $display("FAIL flush_cycle: got vld,pop=%b%b dat=%h want 10 dat=cc", sa_vld, sa_pop, sa_dat);
    end
    flush = 1'b0;
    cycle();
    tests_run++;
    if ({sa_vld, sa_busy, sa_pop} !== 3'b001) begin
      tests_failed++;
      $display("FAIL flush_after: got vld,busy,pop=%b want 001", {sa_vld, sa_busy, sa_pop});
    end
    for (int k = 0; k < 4; k++) begin
      cycle();
      tests_run++;
      if ({sa_vld, sa_last, sa_dat} !== {1'b1, (k == 3), beat_of(w2, k)}) begin
        tests_failed++;
        $display("FAIL flush_restart%0d: got vld,last=%b%b dat=%h want 1%b dat=%h",
                 k, sa_vld, sa_last, sa_dat, (k == 3), beat_of(w2, k));
      end
    end
    cycle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] w2 = 32'h87654321;
    ready = 1'b1;
    fqa.push_back(32'hDDCCBBAA); upd();
    cycle();
    cycle();
    fqa.push_back(w2); upd();
    rst_n = 1'b0;
    cycle();
    tests_run++;
    if ({sa_pop, sa_vld, sa_dat} !== {2'b01, 8'hBB}) begin
      tests_failed++;
      $display("FAIL rstmid_during: got pop,vld=%b%b dat=%h want 01 dat=bb", sa_pop, sa_vld, sa_dat);
    end
    rst_n = 1'b1;
    cycle();
    tests_run++;
    if ({sa_vld, sa_busy, sa_last, sa_dat} !== 11'h000) begin
      tests_failed++;
      $display("FAIL rstmid_after: got vld,busy,last=%b dat=%h want 000 dat=00",
               {sa_vld, sa_busy, sa_last}, sa_dat);
    end
    for (int k = 0; k < 4; k++) begin
      cycle();
      tests_run++;
      if ({sa_vld, sa_last, sa_dat} !== {1'b1, (k == 3), beat_of(w2, k)}) begin
        tests_failed++;
        $display("FAIL rstmid_next%0d: got vld,last=%b%b dat=%h want 1%b dat=%h",
                 k, sa_vld, sa_last, sa_dat, (k == 3), beat_of(w2, k));
      end
    end
    cycle();
  endtask

  task automatic test_ratio1();
    logic [7:0] ws[3] = '{8'h5A, 8'hA5, 8'h3C};
    ready = 1'b1;
    for (int k = 0; k < 3; k++) fqb.push_back(ws[k]);
    upd();
    cycle();
    tests_run++;
    if ({sb_pop, sb_vld} !== 2'b10) begin
      tests_failed++;
      $display("FAIL r1_first_pop: got pop,vld=%b want 10", {sb_pop, sb_vld});
    end
    for (int k = 0; k < 3; k++) begin
      cycle();
      tests_run++;
      if ({sb_vld, sb_last, sb_pop, sb_dat} !== {2'b11, (k < 2), ws[k]}) begin
        tests_failed++;
        $display("FAIL r1_beat%0d: got vld,last,pop=%b%b%b dat=%h want 11%b dat=%h",
                 k, sb_vld, sb_last, sb_pop, sb_dat, (k < 2), ws[k]);
      end
    end
    cycle();
    tests_run++;
    if ({sb_vld, sb_busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL r1_idle: got vld,busy=%b want 00", {sb_vld, sb_busy});
    end
  endtask

  // Reference: the beats still owed for the held word, refilled whenever a word should be popped.
  task automatic test_random();
    logic [7:0]  rem[$];
    logic        e_vld, e_hs, e_pop, e_last;
    logic [7:0]  e_dat, tmp;
    logic [31:0] head;
    for (int c = 0; c < 400; c++) begin
      ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 19) == 0);
      if (fqa.size() < 3 && $urandom_range(0, 2) == 0) fqa.push_back($urandom);
      upd();
      e_vld  = (rem.size() != 0);
      e_hs   = e_vld && ready;
      e_pop  = !flush && (fqa.size() != 0) && (!e_vld || (e_hs && rem.size() == 1));
      e_dat  = e_vld ? rem[0] : 8'h00;
      e_last = (rem.size() == 1);
      head   = (fqa.size() != 0) ? fqa[0] : 32'h0;
      cycle();
      tests_run++;
      if ({sa_vld, sa_busy, sa_pop} !== {e_vld, e_vld, e_pop}) begin
        tests_failed++;
        $display("FAIL rand_ctl c=%0d: got vld,busy,pop=%b want %b",
                 c, {sa_vld, sa_busy, sa_pop}, {e_vld, e_vld, e_pop});
      end
      if (e_vld) begin
        tests_run++;
        if ({sa_last, sa_dat} !== {e_last, e_dat}) begin
          tests_failed++;
          $display("FAIL rand_beat c=%0d: got last=%b dat=%h want last=%b dat=%h",
                   c, sa_last, sa_dat, e_last, e_dat);
        end
      end
      if (flush) rem.delete();
      else if (e_hs) tmp = rem.pop_front();
      if (e_pop) for (int k = 0; k < 4; k++) rem.push_back(beat_of(head, k));
    end
    flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ready = 1'b0;
    upd();
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid();
    test_ratio1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
